rr_arb16: RTL and testbench

//  Round-robin arbiter sharing one 16-way resource among 16 requesters.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/gnt_dec4to16.sv | 17 +
 rtl/rr_arb16.sv | 115 +++++++++++
 tb/tb_rr_arb16.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request scanning ptr, ptr+1, ... with 4-bit wrap.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gnt_dec4to16.sv
// 4-to-16 enable decoder driving the one-hot grant bus.
module gnt_dec4to16
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] w,
    input  logic             en,
    output logic [0:N_REQ-1] y
);

    always_comb begin
        y = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            y[k] = en && (w == IDX_W'(k));
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter: one owner of 16 at a time, released on done,
// withdrawal or hold timeout, with same-cycle hand-over to the next requester.
module rr_arb16
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [0:N_REQ-1] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic             at_limit_c;
    logic             release_c;
    logic [N_REQ-1:0] pick_req_c;
    logic [IDX_W-1:0] pick_ptr_c;
    pick_t            pick_c;

    // Next-state logic; one rr_pick serves both idle arbitration and hand-over.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        at_limit_c = (hold_cnt_q == HOLD_LAST);
        release_c  = done || !req[gnt_idx_q] || at_limit_c;

        // On hand-over the old owner is masked so it cannot win back immediately.
        if (state_q == IDLE) begin
            pick_req_c = req;
            pick_ptr_c = ptr_q;
        end else begin
            pick_req_c = req & ~(N_REQ'(1) << gnt_idx_q);
            pick_ptr_c = gnt_idx_q + IDX_W'(1);
        end
        pick_c = rr_pick(pick_req_c, pick_ptr_c);

        case (state_q)
            IDLE: begin
                if (pick_c.found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = pick_c.idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    timeout_d  = at_limit_c && !done;
                    ptr_d      = gnt_idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    if (pick_c.found) begin
                        gnt_idx_d = pick_c.idx;
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    gnt_dec4to16 u_dec (
        .w  (gnt_idx_q),
        .en (gnt_valid_q),
        .y  (gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb16.sv
// Scoreboard bench for rr_arb16: a queue-based reference model predicts each
// cycle's outputs and an independent monitor compares them.
module tb_rr_arb16;

    localparam int unsigned HOLD_MAX = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [0:15] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    rr_arb16 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [3:0] idx;
        logic       tout;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int tout_cnt = 0;

    // Reference model state: owner (-1 = none), scan start, cycles held so far.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_idx;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_idx   = 0;
    endtask

    // One rising edge of arbitration as described by the rules.
    task automatic model_step(input logic [15:0] r, input logic d, output exp_t e);
        int  nw;
        int  k;
        bit  forced;
        e.tout = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < 16; i++) begin
                k = (m_ptr + i) % 16;
                if (r[k]) begin
                    m_owner = k;
                    m_idx   = k;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            forced = (m_held == int'(HOLD_MAX));
            if (d || !r[m_owner] || forced) begin
                e.tout = forced && !d;
                m_ptr  = (m_owner + 1) % 16;
                nw     = -1;
                for (int i = 0; i < 16; i++) begin
                    k = (m_ptr + i) % 16;
                    if (r[k] && k != m_owner) begin
                        nw = k;
                        break;
                    end
                end
                m_owner = nw;
                if (nw >= 0) begin
                    m_idx  = nw;
                    m_held = 1;
                end
            end else begin
                m_held++;
            end
        end
        e.valid = (m_owner >= 0);
        e.idx   = 4'(m_idx);
    endtask

    task automatic drive(input logic [15:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d, e);
        exp_q.push_back(e);
    endtask

    task automatic expect_now(input string name, input logic v, input logic [3:0] idx, input logic t);
        @(posedge clk);
        #2;
        check({name, "_valid"}, 32'(gnt_valid), 32'(v));
        if (v) check({name, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({name, "_timeout"}, 32'(timeout), 32'(t));
    endtask

    // Asynchronous reset landing between clock edges.
    task automatic do_reset(input string name);
        logic [15:0] g;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) g[k] = gnt[k];
        check({name, "_gnt"}, 32'(g), 32'h0);
        check({name, "_gnt_valid"}, 32'(gnt_valid), 32'h0);
        check({name, "_gnt_idx"}, 32'(gnt_idx), 32'h0);
        check({name, "_timeout"}, 32'(timeout), 32'h0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: invariants every cycle, plus scoreboard comparison when an entry is due.
    initial begin
        exp_t        e;
        logic [15:0] g;
        logic [15:0] eg;
        int          run;
        logic [3:0]  last_idx;
        logic        last_valid;
        run        = 0;
        last_idx   = '0;
        last_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int k = 0; k < 16; k++) g[k] = gnt[k];
                check("onehot0", 32'($onehot0(g)), 32'h1);
                check("valid_eq_or_gnt", 32'(gnt_valid), 32'(|g));
                if (gnt_valid && last_valid && gnt_idx == last_idx) run++;
                else run = gnt_valid ? 1 : 0;
                check("hold_le_max", 32'(run <= int'(HOLD_MAX)), 32'h1);
                last_idx   = gnt_idx;
                last_valid = gnt_valid;
                if (timeout) tout_cnt++;
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    eg = e.valid ? (16'h1 << e.idx) : 16'h0;
                    check("sb_valid", 32'(gnt_valid), 32'(e.valid));
                    check("sb_idx", 32'(gnt_idx), 32'(e.idx));
                    check("sb_timeout", 32'(timeout), 32'(e.tout));
                    check("sb_gnt", 32'(g), 32'(eg));
                end
            end else begin
                run        = 0;
                last_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [15:0] r;
        logic        d;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        #12;
        check("por_gnt_valid", 32'(gnt_valid), 32'h0);
        check("por_gnt_idx", 32'(gnt_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, release by done, then wrap of the pointer.
        drive(16'h0010, 1'b0);
        expect_now("t2_first", 1'b1, 4'd4, 1'b0);
        drive(16'h0010, 1'b0);
        drive(16'h0010, 1'b1);
        expect_now("t2_released", 1'b0, 4'd0, 1'b0);
        drive(16'h0011, 1'b0);
        expect_now("t2_ptr5", 1'b1, 4'd0, 1'b0);
        drive(16'h0011, 1'b0);

        // Reset mid-grant.
        do_reset("t1_rst");

        // Round robin over all requesters with done every other cycle.
        for (int i = 0; i < 36; i++) drive(16'hFFFF, 1'(i % 2));

        // Hold timeout between requesters 0 and 15.
        do_reset("t4_rst");
        tout_cnt = 0;
        for (int i = 0; i < 17; i++) drive(16'h8001, 1'b0);
        expect_now("t4_wrap", 1'b1, 4'd0, 1'b1);
        check("t4_timeouts", 32'(tout_cnt), 32'd2);

        // Withdrawal hand-over, then done coinciding with the hold limit.
        do_reset("t5_rst");
        drive(16'h0208, 1'b0);
        expect_now("t5_own3", 1'b1, 4'd3, 1'b0);
        drive(16'h0200, 1'b0);
        expect_now("t5_withdraw", 1'b1, 4'd9, 1'b0);
        for (int i = 0; i < 7; i++) drive(16'h0208, 1'b0);
        drive(16'h0208, 1'b1);
        expect_now("t5_done_at_limit", 1'b1, 4'd3, 1'b0);

        // Randomized traffic with slowly changing request levels.
        r = 16'($urandom);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 16'($urandom);
                if ($urandom_range(0, 1) == 1) r = r & 16'($urandom) & 16'($urandom);
                if ($urandom_range(0, 9) == 0) r = '0;
            end
            d = ($urandom_range(0, 3) == 0);
            drive(r, d);
        end

        @(posedge clk);
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
